cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Sequencing FSM for the direct-mapped cache line array; sits between the CPU load/store port and the block-wide main-memory port.
- Splits CPU addresses into tag/index/word, drives lookup, write-hit and line-fill controls, and performs dirty write-back before refill.
- The line array exposes neither tag nor dirty bit, so the controller keeps per-line shadow valid/dirty/tag state.
- Also keeps hit/miss performance counters.

Parameters:
LINES, 32, number of cache lines
TAG_BITS, 6, tag width
BLOCK_BITS, 128, line width (4 x 32-bit words)
ADDR_BITS, TAG_BITS+$clog2(LINES)+4, CPU byte-address width (15 at defaults)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
cpu_req  in  1  request valid; sampled only in IDLE
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_BITS  byte address; [3:2] word, [1:0] ignored
cpu_wdata  in  32  store data
cpu_ready  out  1  one-cycle completion pulse
cpu_rdata  out  32  load data, valid while cpu_ready=1
cpu_busy  out  1  high in every state except IDLE
c_tag  out  TAG_BITS  to line array tag_in
c_index  out  $clog2(LINES)  to line array index
c_word_sel  out  2  to line array word_sel
c_write_en  out  1  to line array write_en
c_write_data  out  32  to line array write_data
c_hit  in  1  from line array hit
c_read_word  in  32  from line array read_word
c_block_out  in  BLOCK_BITS  from line array block_out
c_block_in  out  BLOCK_BITS  to line array block_in
c_load_line  out  1  to line array load_line
mem_req  out  1  memory request
mem_we  out  1  1 = write-back, 0 = refill
mem_addr  out  ADDR_BITS  block-aligned address, [3:0]=0
mem_wdata  out  BLOCK_BITS  write-back block
mem_rdata  in  BLOCK_BITS  refill block, valid with mem_ready
mem_ready  in  1  memory completion, single-cycle
hit_count  out  16  lookup hits, wraps at 16'hFFFF
miss_count  out  16  lookup misses, wraps

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0: cpu_ready, cpu_rdata, cpu_busy, mem_req, mem_we, c_write_en, c_load_line, counters. Shadow valid/dirty/tag cleared.
- Request latch: in IDLE, cpu_req=1 latches addr/we/wdata into req_* registers -> LOOKUP. c_tag, c_index, c_word_sel, c_write_data always come from req_* and stay stable until DONE.
- LOOKUP, c_hit=1: hit_count++.
  - Load: register c_read_word into cpu_rdata.
  - Store: assert c_write_en this cycle; set shadow dirty[index].
  - Next state DONE.
- LOOKUP, c_hit=0:
  - miss_count++; c_write_en stays 0.
  - Shadow valid&dirty[index] -> WRITEBACK, else REFILL.
  - A re-lookup after a fill never counts again; a per-request flag suppresses the second count.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={shadow_tag[index], index, 4'b0}, mem_wdata=c_block_out. All held stable until mem_ready=1 -> REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr={req_tag, req_index, 4'b0}.
  - On mem_ready: c_load_line=1, c_block_in=mem_rdata (combinational, same cycle).
  - Shadow tag=req_tag, valid=1, dirty=0 -> LOOKUP (guaranteed hit).
- DONE: cpu_ready=1 for exactly one cycle -> IDLE. cpu_rdata holds its value until the next load hit.
- Latency from the cpu_req sample edge:
  - Hit: cpu_ready 2 cycles later.
  - Clean miss: 4 cycles + refill wait.
  - Dirty miss: adds write-back wait.
- Invariants:
  - c_write_en and c_load_line are never asserted in the same cycle.
  - mem_req never drops before mem_ready.
  - mem_ready outside WRITEBACK/REFILL is ignored.
- cpu_req outside IDLE is ignored; the requester must hold it until cpu_ready.
- Reset mid-WRITEBACK/REFILL aborts the transfer; mem_req drops asynchronously. Line array is reset in parallel, so shadow and array agree.

Test Plan:
- Cold load to addr 0x0124 (tag 0, index 18, word 1), mem_rdata={32'hD,32'hC,32'hB,32'hA}, mem_ready after 3 cycles -> one refill at mem_addr 0x0120, c_load_line 1 cycle, cpu_rdata=32'hB, miss_count=1, hit_count=1.
- Store 32'hCAFE to 0x0124 after the fill -> c_write_en 1 cycle, cpu_ready 2 cycles after sample, no mem_req, shadow dirty[18]=1.
- Load 0x0524 (tag 2, index 18) with line 18 dirty -> WRITEBACK at mem_addr 0x0120 carrying word1=32'hCAFE, then REFILL at 0x0520, correct cpu_rdata.
- mem_ready held low 20 cycles during REFILL -> mem_req, mem_addr and mem_we stable throughout; cpu_busy=1; no cpu_ready.
- Assert reset 2 cycles into REFILL -> mem_req, cpu_busy and counters 0 immediately; next load to the same address misses again.
- Back-to-back hits (cpu_req held, new addr the cycle after cpu_ready) -> each completes in 2 cycles, hit_count increments per request.

Source files
------------

// File: rtl/cache_ctrl.sv
// Sequencing FSM for a direct-mapped cache line array: lookup, store hit,
// dirty write-back, and line refill. Keeps shadow valid/dirty/tag state and hit/miss counters.
module cache_ctrl #(
  parameter int LINES      = 32,
  parameter int TAG_BITS   = 6,
  parameter int BLOCK_BITS = 128,
  parameter int ADDR_BITS  = TAG_BITS + $clog2(LINES) + 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDR_BITS-1:0]     cpu_addr,
  input  logic [31:0]              cpu_wdata,
  output logic                     cpu_ready,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_busy,
  output logic [TAG_BITS-1:0]      c_tag,
  output logic [$clog2(LINES)-1:0] c_index,
  output logic [1:0]               c_word_sel,
  output logic                     c_write_en,
  output logic [31:0]              c_write_data,
  input  logic                     c_hit,
  input  logic [31:0]              c_read_word,
  input  logic [BLOCK_BITS-1:0]    c_block_out,
  output logic [BLOCK_BITS-1:0]    c_block_in,
  output logic                     c_load_line,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_BITS-1:0]     mem_addr,
  output logic [BLOCK_BITS-1:0]    mem_wdata,
  input  logic [BLOCK_BITS-1:0]    mem_rdata,
  input  logic                     mem_ready,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count
);
  localparam int IDX_BITS = $clog2(LINES);

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, DONE} state_t;
  state_t state, state_nx;

  logic [TAG_BITS-1:0] req_tag;
  logic [IDX_BITS-1:0] req_index;
  logic [1:0]          req_word;
  logic                req_we;
  logic [31:0]         req_wdata;
  logic                req_counted;

  logic [LINES-1:0]    sh_valid;
  logic [LINES-1:0]    sh_dirty;
  logic [TAG_BITS-1:0] sh_tag [LINES];

  // Byte-offset bits select nothing; folded here so they are visibly unused.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign c_tag        = req_tag;
  assign c_index      = req_index;
  assign c_word_sel   = req_word;
  assign c_write_data = req_wdata;
  assign c_block_in   = mem_rdata;
  assign mem_wdata    = c_block_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    cpu_ready   = 1'b0;
    cpu_busy    = (state != IDLE);
    c_write_en  = 1'b0;
    c_load_line = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    case (state)
      IDLE:   if (cpu_req) state_nx = LOOKUP;
      LOOKUP: begin
        if (c_hit) begin
          c_write_en = req_we;
          state_nx   = DONE;
        end else if (sh_valid[req_index] && sh_dirty[req_index]) begin
          state_nx = WRITEBACK;
        end else begin
          state_nx = REFILL;
        end
      end
      WRITEBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {sh_tag[req_index], req_index, 4'b0};
        if (mem_ready) state_nx = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_index, 4'b0};
        if (mem_ready) begin
          c_load_line = 1'b1;
          state_nx    = LOOKUP;
        end
      end
      DONE: begin
        cpu_ready = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_tag     <= '0;
      req_index   <= '0;
      req_word    <= '0;
      req_we      <= 1'b0;
      req_wdata   <= '0;
      req_counted <= 1'b0;
      cpu_rdata   <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      sh_valid    <= '0;
      sh_dirty    <= '0;
      for (int i = 0; i < LINES; i++) sh_tag[i] <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req) begin
          req_tag     <= cpu_addr[4+IDX_BITS +: TAG_BITS];
          req_index   <= cpu_addr[4 +: IDX_BITS];
          req_word    <= cpu_addr[3:2];
          req_we      <= cpu_we;
          req_wdata   <= cpu_wdata;
          req_counted <= 1'b0;
        end
        LOOKUP: begin
          if (c_hit) begin
            hit_count <= hit_count + 16'd1;
            if (req_we) sh_dirty[req_index] <= 1'b1;
            else        cpu_rdata <= c_read_word;
          end else if (!req_counted) begin
            // The post-fill re-lookup must not count the same miss twice.
            miss_count  <= miss_count + 16'd1;
            req_counted <= 1'b1;
          end
        end
        REFILL: if (mem_ready) begin
          sh_tag[req_index]   <= req_tag;
          sh_valid[req_index] <= 1'b1;
          sh_dirty[req_index] <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural line array and a hand-driven memory.
module tb_cache_ctrl;
  logic         clk, reset;
  logic         cpu_req, cpu_we;
  logic [14:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_ready, cpu_busy;
  logic [31:0]  cpu_rdata;
  logic [5:0]   c_tag;
  logic [4:0]   c_index;
  logic [1:0]   c_word_sel;
  logic         c_write_en, c_hit, c_load_line;
  logic [31:0]  c_write_data, c_read_word;
  logic [127:0] c_block_out, c_block_in;
  logic         mem_req, mem_we, mem_ready;
  logic [14:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic [15:0]  hit_count, miss_count;

  cache_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
    .c_tag(c_tag), .c_index(c_index), .c_word_sel(c_word_sel),
    .c_write_en(c_write_en), .c_write_data(c_write_data),
    .c_hit(c_hit), .c_read_word(c_read_word), .c_block_out(c_block_out),
    .c_block_in(c_block_in), .c_load_line(c_load_line),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural line array; valid bits reset alongside the controller.
  logic [127:0] la_data  [32];
  logic [5:0]   la_tag   [32];
  logic         la_valid [32];
  assign c_hit       = la_valid[c_index] && (la_tag[c_index] == c_tag);
  assign c_block_out = la_data[c_index];
  assign c_read_word = la_data[c_index][c_word_sel*32 +: 32];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) la_valid[i] <= 1'b0;
    end else begin
      if (c_load_line) begin
        la_data[c_index]  <= c_block_in;
        la_tag[c_index]   <= c_tag;
        la_valid[c_index] <= 1'b1;
      end
      if (c_write_en) la_data[c_index][c_word_sel*32 +: 32] <= c_write_data;
    end
  end

  int n_load = 0, n_we = 0, n_memreq = 0;
  logic both_seen = 1'b0;
  always @(posedge clk) begin
    if (c_load_line) n_load++;
    if (c_write_en)  n_we++;
    if (mem_req)     n_memreq++;
    if (c_write_en && c_load_line) both_seen = 1'b1;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int max, output int n);
    n = 0;
    while (cpu_ready !== 1'b1 && n < max) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    int n;
    int memreq_before;
    logic bad;
    for (int i = 0; i < 32; i++) begin
      la_data[i] = '0;
      la_tag[i]  = '0;
    end
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cpu_ready, 0);
    chk("rst_busy", cpu_busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_counts", {hit_count, miss_count}, 0);
    reset = 1'b0;

    // Cold load 0x0124: tag 0, index 18, word 1
    cpu_req = 1'b1; cpu_addr = 15'h0124;
    cyc();
    chk("lk_busy", cpu_busy, 1);
    chk("lk_fields", {c_tag, c_index, c_word_sel}, {6'd0, 5'd18, 2'd1});
    cyc();
    chk("cold_req", {mem_req, mem_we}, 2'b10);
    chk("cold_addr", mem_addr, 15'h0120);
    chk("cold_miss", miss_count, 1);
    cyc(); cyc();
    mem_ready = 1'b1; mem_rdata = {32'hD, 32'hC, 32'hB, 32'hA};
    #1;
    chk("cold_load_line", c_load_line, 1);
    cyc();
    mem_ready = 1'b0;
    cyc();
    chk("cold_ready", cpu_ready, 1);
    chk("cold_rdata", cpu_rdata, 32'hB);
    chk("cold_counts", {hit_count, miss_count}, {16'd1, 16'd1});
    cpu_req = 1'b0;
    cyc();
    chk("cold_idle", {cpu_ready, cpu_busy}, 2'b00);
    chk("cold_nload", n_load, 1);

    // Store hit 0xCAFE to 0x0124
    memreq_before = n_memreq;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_wdata = 32'hCAFE;
    cyc();
    chk("st_we", c_write_en, 1);
    chk("st_wdata", c_write_data, 32'hCAFE);
    cyc();
    chk("st_ready", {cpu_ready, c_write_en}, 2'b10);
    chk("st_hits", hit_count, 2);
    cpu_req = 1'b0; cpu_we = 1'b0;
    cyc();
    chk("st_no_mem", n_memreq, memreq_before);

    // Dirty miss 0x0524: tag 2, index 18
    cpu_req = 1'b1; cpu_addr = 15'h0524;
    cyc(); cyc();
    chk("wb_req", {mem_req, mem_we}, 2'b11);
    chk("wb_addr", mem_addr, 15'h0120);
    chk("wb_data", mem_wdata, {32'hD, 32'hC, 32'hCAFE, 32'hA});
    chk("wb_miss", miss_count, 2);
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    chk("rf_req", {mem_req, mem_we}, 2'b10);
    chk("rf_addr", mem_addr, 15'h0520);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'h0520 ||
          cpu_busy !== 1'b1 || cpu_ready !== 1'b0) bad = 1'b1;
    end
    chk("rf_stall_stable", bad, 0);
    mem_ready = 1'b1; mem_rdata = {32'h8, 32'h7, 32'h6, 32'h5};
    cyc();
    mem_ready = 1'b0;
    cyc();
    chk("dm_ready", cpu_ready, 1);
    chk("dm_rdata", cpu_rdata, 32'h6);
    chk("dm_counts", {hit_count, miss_count}, {16'd3, 16'd2});
    cpu_req = 1'b0;
    cyc();

    // Reset two cycles into REFILL of 0x0924
    cpu_req = 1'b1; cpu_addr = 15'h0924;
    cyc(); cyc();
    chk("ab_refill", {mem_req, mem_we}, 2'b10);
    cyc();
    reset = 1'b1;
    #1;
    chk("ab_mem_req", mem_req, 0);
    chk("ab_busy", cpu_busy, 0);
    chk("ab_counts", {hit_count, miss_count}, 0);
    cyc();
    reset = 1'b0;
    cyc(); cyc();
    chk("ab_remiss", miss_count, 1);
    chk("ab_readdr", {mem_req, mem_addr}, {1'b1, 15'h0920});
    mem_ready = 1'b1; mem_rdata = {32'h44, 32'h33, 32'h22, 32'h11};
    cyc();
    mem_ready = 1'b0;
    cyc();
    chk("ab_ready", cpu_ready, 1);
    chk("ab_rdata", cpu_rdata, 32'h22);

    // Back-to-back hits with cpu_req held
    cpu_addr = 15'h0928;
    cyc();
    wait_ready(10, n);
    chk("b2b1_lat", n, 2);
    chk("b2b1_rdata", cpu_rdata, 32'h33);
    chk("b2b1_hits", hit_count, 2);
    cpu_addr = 15'h092C;
    cyc();
    wait_ready(10, n);
    chk("b2b2_lat", n, 2);
    chk("b2b2_rdata", cpu_rdata, 32'h44);
    chk("b2b2_hits", {hit_count, miss_count}, {16'd3, 16'd1});
    cpu_req = 1'b0;
    cyc();

    chk("never_we_and_load", both_seen, 0);
    chk("total_we", n_we, 1);
    chk("total_load", n_load, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
